branch_target_buffer: RTL
=========================

# branch_target_buffer

Branch predictor and mispredict controller for the RV32I pipelined core. Looks up the IF-stage PC in a direct-mapped branch target buffer holding 2-bit saturating counters and supplies a predicted next PC. When a branch resolves in EX, it takes the taken/not-taken outcome from the branch decision unit, updates the table, and raises a flush/redirect to the hazard unit on a mispredict. It also keeps branch and mispredict statistics.

## Interface
Parameters:
- IDX_W, 6, index width; ENTRIES = 2^IDX_W
- Tag width is fixed at 30 - IDX_W.

Ports:
- clk  in  1  core clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- pc_if  in  32  PC being fetched
- pred_taken_if  out  1  prediction for pc_if: taken
- pred_target_if  out  32  predicted target; 0 when pred_taken_if=0
- upd_en  in  1  EX holds a valid conditional branch; parent drives 0 on bubble or stall
- pc_ex  in  32  PC of the EX branch
- br_ex  in  1  resolved outcome from branch decision
- target_ex  in  32  computed branch target
- pred_taken_ex  in  1  pred_taken_if, pipelined to EX
- pred_target_ex  in  32  pred_target_if, pipelined to EX
- mispredict  out  1  flush IF/ID and ID/EX; redirect fetch
- redirect_pc  out  32  correct next PC, valid when mispredict=1
- br_cnt  out  32  number of resolved branches
- miss_cnt  out  32  number of mispredicts

## Operation
- Index is pc[IDX_W+1:2]; tag is pc[31:IDX_W+2]. Each entry holds valid, tag, target[31:0] and ctr[1:0].
- Counter states: SNT=00, WNT=01, WT=10, ST=11. The prediction is taken when ctr[1]=1.
- Lookup (combinational): hit = valid[idx_if] && tag match. pred_taken_if = hit && ctr[1]. pred_target_if = target when pred_taken_if=1, otherwise 0.
- Mispredict (combinational, gated by upd_en):
  - fires when pred_taken_ex != br_ex;
  - also fires when pred_taken_ex && br_ex && pred_target_ex != target_ex.
- redirect_pc = br_ex ? target_ex : pc_ex + 4. The add wraps modulo 2^32. redirect_pc is 0 when mispredict=0.
- Table update at the clock edge, only when upd_en=1, using index/tag from pc_ex:
  - Hit, taken: ctr increments, saturating at ST; target is overwritten with target_ex.
  - Hit, not taken: ctr decrements, saturating at SNT; target is unchanged.
  - Miss, taken: the entry is allocated or replaced with valid=1, the new tag, target=target_ex, ctr=WT.
  - Miss, not taken: no change to the table.
- Statistics, when upd_en=1: br_cnt += 1, and miss_cnt += mispredict. Both wrap modulo 2^32.

## Timing
- Reset values: all valid=0; all ctr=WNT; br_cnt=0; miss_cnt=0.
  - As a result, pred_taken_if=0, pred_target_if=0, mispredict=0 and redirect_pc=0 while no update is pending.
  - Reset asserted mid-operation clears all of this immediately; any pending update is discarded.
- Lookup and mispredict are zero-latency (same cycle). Table and counter updates become visible from the cycle after the edge.
- Same index looked up in IF and updated in EX in the same cycle: IF sees the old entry. There is no bypass.
- upd_en=0: the table and counters hold, and mispredict=0 regardless of the other EX inputs.
- A mispredict is taken from a single cycle. The parent flushes on it; this block does not hold the request.

## Structure
- The shared package holds:
  - the counter encodings SNT/WNT/WT/ST;
  - the reset counter value WNT;
  - the allocation value WT.
- One sub-module: btb_table.
  - Storage arrays with one combinational read port (IF) and one synchronous write port (EX).
  - Asynchronous reset of the valid and ctr arrays.
- The top level holds the counter update logic, the mispredict compare, redirect_pc and the statistics counters.

## Test plan
- Reset, then pc_if=0x100 -> pred_taken_if=0, pred_target_if=0, br_cnt=0.
- Cold taken branch: upd_en=1, pc_ex=0x100, br_ex=1, target_ex=0x180, pred_taken_ex=0.
  - Same cycle: mispredict=1, redirect_pc=0x180, miss_cnt becomes 1.
  - Next cycle, pc_if=0x100: pred_taken_if=1, pred_target_if=0x180.
- Counter walk on 0x100: two not-taken resolutions (WT->WNT->SNT) -> pred_taken_if=0. One more not-taken leaves ctr=SNT. Then one taken -> ctr=WNT, still predicts not taken.
- Wrong target: entry predicts 0x180; EX resolves taken with target_ex=0x1C0 -> mispredict=1, redirect_pc=0x1C0, and the stored target becomes 0x1C0.
- Alias and wrap:
  - With IDX_W=6, pc 0x100 and 0x200 share index 0. A taken branch at 0x200 replaces the entry, and pc_if=0x100 then misses.
  - A not-taken mispredict at pc_ex=0xFFFFFFFC gives redirect_pc=0x00000000.
- Bubble and simultaneity:
  - upd_en=0 with br_ex=1 -> no mispredict and no counter change.
  - Lookup and update of the same index in one cycle -> the IF output reflects the pre-update entry.
  - rst asserted mid-update -> the entry stays invalid.

Source files
------------

// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer: 2-bit saturating counter
// encodings and the counter helpers used by the update logic.
package branch_target_buffer_pkg;

   typedef enum logic [1:0] {
      CtrSnt = 2'b00,
      CtrWnt = 2'b01,
      CtrWt  = 2'b10,
      CtrSt  = 2'b11
   } ctr_e;

   localparam ctr_e CtrReset = CtrWnt;
   localparam ctr_e CtrAlloc = CtrWt;

   function automatic ctr_e ctr_inc(ctr_e c);
      return (c == CtrSt) ? CtrSt : ctr_e'(c + 2'd1);
   endfunction

   function automatic ctr_e ctr_dec(ctr_e c);
      return (c == CtrSnt) ? CtrSnt : ctr_e'(c - 2'd1);
   endfunction

   function automatic logic ctr_taken(ctr_e c);
      return (c == CtrWt) || (c == CtrSt);
   endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: combinational lookup port for IF, combinational
// read plus synchronous write port for EX. Valid and counters reset async.
module btb_table
   import branch_target_buffer_pkg::*;
#(
   parameter int unsigned IDX_W = 6,
   localparam int unsigned TAG_W = 30 - IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   // IF lookup
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [TAG_W-1:0] rd_tag,
   output logic             rd_hit,
   output ctr_e             rd_ctr,
   output logic [31:0]      rd_target,
   // EX read-modify-write
   input  logic [IDX_W-1:0] ex_idx,
   input  logic [TAG_W-1:0] ex_tag,
   output logic             ex_hit,
   output ctr_e             ex_ctr,
   input  logic             wr_en,
   input  logic             wr_tgt_en,
   input  ctr_e             wr_ctr,
   input  logic [31:0]      wr_target
);

   localparam int ENTRIES = 1 << IDX_W;

   logic             valid_q  [ENTRIES];
   ctr_e             ctr_q    [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];

   assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign rd_ctr    = ctr_q[rd_idx];
   assign rd_target = target_q[rd_idx];

   assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
   assign ex_ctr = ctr_q[ex_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= CtrReset;
         end
      end else if (wr_en) begin
         valid_q[ex_idx] <= 1'b1;
         ctr_q[ex_idx]   <= wr_ctr;
      end
   end

   // Tag and target need no reset: they are only observed behind valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[ex_idx] <= ex_tag;
      end
      if (wr_tgt_en) begin
         target_q[ex_idx] <= wr_target;
      end
   end

endmodule

// File: rtl/branch_target_buffer.sv
// Branch predictor and mispredict controller: IF-stage BTB lookup, EX-stage
// resolution with table update, flush/redirect generation and statistics.
module branch_target_buffer
   import branch_target_buffer_pkg::*;
#(
   parameter int unsigned IDX_W = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_if,
   output logic        pred_taken_if,
   output logic [31:0] pred_target_if,
   input  logic        upd_en,
   input  logic [31:0] pc_ex,
   input  logic        br_ex,
   input  logic [31:0] target_ex,
   input  logic        pred_taken_ex,
   input  logic [31:0] pred_target_ex,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] br_cnt,
   output logic [31:0] miss_cnt
);

   localparam int unsigned TAG_W = 30 - IDX_W;

   logic [IDX_W-1:0] idx_if, idx_ex;
   logic [TAG_W-1:0] tag_if, tag_ex;
   logic             hit_if, hit_ex;
   ctr_e             ctr_if, ctr_ex;
   logic [31:0]      target_if;
   logic             wr_en, wr_tgt_en;
   ctr_e             wr_ctr;
   logic             dir_miss, tgt_miss;
   logic [31:0]      pc_ex_plus4;
   logic [31:0]      br_cnt_q, miss_cnt_q;
   logic             unused_pc_if;

   assign idx_if = pc_if[IDX_W+1:2];
   assign tag_if = pc_if[31:IDX_W+2];
   assign idx_ex = pc_ex[IDX_W+1:2];
   assign tag_ex = pc_ex[31:IDX_W+2];
   assign unused_pc_if = ^pc_if[1:0];

   btb_table #(
      .IDX_W (IDX_W)
   ) u_table (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (idx_if),
      .rd_tag    (tag_if),
      .rd_hit    (hit_if),
      .rd_ctr    (ctr_if),
      .rd_target (target_if),
      .ex_idx    (idx_ex),
      .ex_tag    (tag_ex),
      .ex_hit    (hit_ex),
      .ex_ctr    (ctr_ex),
      .wr_en     (wr_en),
      .wr_tgt_en (wr_tgt_en),
      .wr_ctr    (wr_ctr),
      .wr_target (target_ex)
   );

   assign pred_taken_if  = hit_if && ctr_taken(ctr_if);
   assign pred_target_if = pred_taken_if ? target_if : 32'd0;

   // Direction wrong, or taken-and-taken but to the wrong place.
   assign dir_miss    = pred_taken_ex != br_ex;
   assign tgt_miss    = pred_taken_ex && br_ex && (pred_target_ex != target_ex);
   assign mispredict  = upd_en && (dir_miss || tgt_miss);
   assign pc_ex_plus4 = pc_ex + 32'd4;
   assign redirect_pc = mispredict ? (br_ex ? target_ex : pc_ex_plus4) : 32'd0;

   always_comb begin
      wr_en     = 1'b0;
      wr_tgt_en = 1'b0;
      wr_ctr    = ctr_ex;
      if (upd_en) begin
         if (hit_ex) begin
            wr_en = 1'b1;
            if (br_ex) begin
               wr_tgt_en = 1'b1;
               wr_ctr    = ctr_inc(ctr_ex);
            end else begin
               wr_ctr = ctr_dec(ctr_ex);
            end
         end else if (br_ex) begin
            // Not-taken misses are not allocated.
            wr_en     = 1'b1;
            wr_tgt_en = 1'b1;
            wr_ctr    = CtrAlloc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_cnt_q   <= 32'd0;
         miss_cnt_q <= 32'd0;
      end else if (upd_en) begin
         br_cnt_q   <= br_cnt_q + 32'd1;
         miss_cnt_q <= miss_cnt_q + {31'd0, mispredict};
      end
   end

   assign br_cnt   = br_cnt_q;
   assign miss_cnt = miss_cnt_q;

endmodule
